ps2_host_tx: RTL

PS/2 host-to-device transmitter: serialises one command byte from the host logic to the PS/2 keyboard, e.g. LED update 0xED, reset 0xFF or typematic 0xF3. It drives the shared open-drain PS2_CLK/PS2_DATA lines through active-low output enables. It runs the full request-to-send, bit-shift and acknowledge sequence. It sits beside the PS/2 receiver in the keyboard subsystem; BUSY tells the receiver to ignore line activity while a frame is in flight.

---
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side bundle for the PS/2 transmitter: byte handshake, status pulses
// and the open-drain pad signals of the PS/2 clock and data lines.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    // Host logic and pad side
    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe
    );

    // Transmitter side
    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift of
// start/data/parity/stop on device clock falls, acknowledge and line-idle wait.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1600,
    parameter int REQUEST_CYCLES = 32,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 240000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);
    localparam int PH_W  = $clog2(INHIBIT_CYCLES + REQUEST_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, FINISH} state_t;

    // Index 0 = PS2_CLK, index 1 = PS2_DATA
    logic [1:0]       sync1_q, sync2_q;
    logic             fclk_q, fclk_d;
    logic [FLT_W-1:0] fcnt_q, fcnt_d;
    logic             fall_q, fall_d;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic             timeout;
    logic             lines_high;

    // Two-flop synchronisers on both pads; idle lines are high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync2_q <= sync1_q;
        end
    end

    // Clock filter: fclk follows the synchronised clock only after it has held
    // a new value for FILTER_CYCLES samples; a fall is flagged one cycle later
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (sync2_q[0] != fclk_q) begin
            if (fcnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
                fclk_d = sync2_q[0];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        fall_d = fclk_q & ~fclk_d;
    end

    assign timeout    = ((state_q == SHIFT) || (state_q == ACK) || (state_q == FINISH))
                        && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    assign lines_high = sync2_q[0] & sync2_q[1];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fclk_q    <= 1'b1;
            fcnt_q    <= '0;
            fall_q    <= 1'b0;
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            fclk_q    <= fclk_d;
            fcnt_q    <= fcnt_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Next-state and datapath update; timeout wins over a same-cycle fall
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    shift_d  = bus.tx_data;
                    parity_d = ~^bus.tx_data;
                    phase_d  = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase_q == PH_W'(INHIBIT_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = REQUEST;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            REQUEST: begin
                if (phase_q == PH_W'(REQUEST_CYCLES - 1)) begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    data_oe_d = 1'b1;   // start bit stays driven until the first fall
                    state_d   = SHIFT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout) begin
                    state_d = IDLE;
                end else if (fall_q) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout) begin
                    state_d = IDLE;
                end else if (fall_q) begin
                    to_cnt_d = '0;
                    ack_ok_d = ~sync2_q[1];
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout || lines_high) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; line drives vanish as soon as state is IDLE
    always_comb begin
        bus.ps2_clk_oe  = 1'b0;
        bus.ps2_data_oe = 1'b0;
        bus.tx_ready    = 1'b0;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.error       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.tx_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            INHIBIT: bus.ps2_clk_oe = 1'b1;
            REQUEST: begin
                bus.ps2_clk_oe  = 1'b1;
                bus.ps2_data_oe = 1'b1;
            end
            SHIFT: begin
                bus.ps2_data_oe = data_oe_q & ~timeout;
                bus.error       = timeout;
            end
            ACK: bus.error = timeout;
            FINISH: begin
                if (timeout) begin
                    bus.error = 1'b1;
                end else if (lines_high) begin
                    bus.done  = ack_ok_q;
                    bus.error = ~ack_ok_q;
                end
            end
            default: ;
        endcase
    end
endmodule
